flip_horizontal_stream: RTL and testbench

//  Streaming horizontal mirror for 24-bit RGB raster images in the image pipeline.

---
 rtl/flip_pkg.sv | 21 ++
 rtl/line_buffer_ram.sv | 35 +++
 rtl/flip_horizontal_stream.sv | 207 ++++++++++++++++++++
 tb/tb_flip_horizontal_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/flip_pkg.sv
// rtl/flip_pkg.sv - shared types and default parameters for the horizontal flip stream
package flip_pkg;

    localparam int DEF_MAX_WIDTH = 4096;
    localparam int DEF_CH_W      = 8;
    localparam int DEF_WIDTH_W   = 13;

    typedef struct packed {
        logic [DEF_CH_W-1:0] r;
        logic [DEF_CH_W-1:0] g;
        logic [DEF_CH_W-1:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - one line bank: single write port, one registered read port
// Ports:
//   clk      : clock
//   i_we     : write enable, i_waddr/i_wdata written on the rising edge
//   i_re     : read enable, o_rdata loads mem[i_raddr] on the rising edge and holds otherwise
module line_buffer_ram
    import flip_pkg::*;
#(
    parameter int DEPTH  = DEF_MAX_WIDTH,
    parameter int DATA_W = 3 * DEF_CH_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        // The read register only moves on i_re; the top relies on that to hold
        // a fetched pixel while the output stage is stalled.
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/flip_horizontal_stream.sv
// rtl/flip_horizontal_stream.sv - streaming horizontal mirror of RGB rows via ping-pong line banks
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   width                 : pixels per row, sampled on each row's first input handshake
//   in_valid/in_ready     : input pixel handshake, r_in/g_in/b_in data
//   out_valid/out_ready   : output pixel handshake, r_out/g_out/b_out data
//   out_eol               : marks the last output pixel of a row (input column 0)
module flip_horizontal_stream
    import flip_pkg::*;
#(
    parameter int MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int CH_W      = DEF_CH_W,
    parameter int WIDTH_W   = DEF_WIDTH_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH_W-1:0] width,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH_W-1:0]    r_in,
    input  logic [CH_W-1:0]    g_in,
    input  logic [CH_W-1:0]    b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    r_out,
    output logic [CH_W-1:0]    g_out,
    output logic [CH_W-1:0]    b_out,
    output logic               out_eol
);

    localparam int PIX_W  = 3 * CH_W;
    localparam int ADDR_W = $clog2(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0] MAX_W_V = WIDTH_W'(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0] ONE     = WIDTH_W'(1);
    localparam logic [WIDTH_W-1:0] TWO     = WIDTH_W'(2);

    bank_state_t        r_st [2];
    bank_state_t        w_st_nxt [2];
    logic [WIDTH_W-1:0] r_bank_w [2];
    logic [PIX_W-1:0]   w_rdata [2];

    logic               r_wr_bank;
    logic [WIDTH_W-1:0] r_wr_col;
    logic               r_rd_bank;
    logic               r_rd_busy;
    logic [WIDTH_W-1:0] r_rd_col;
    logic               r_s1_valid, r_s1_byp, r_s1_eol, r_s1_bank;
    logic [PIX_W-1:0]   r_byp_px;
    logic               r_out_valid, r_out_eol, r_out_bank;
    logic [PIX_W-1:0]   r_out_px;

    logic [PIX_W-1:0]   w_in_px, w_s1_px;
    logic [WIDTH_W-1:0] w_eff_w, w_row_w, w_rd_addr;
    logic               w_row_start, w_wr_open, w_wr_fire, w_wr_last;
    logic               w_rd_start, w_rd_fire, w_rd_last;
    logic               w_out_load, w_s1_free, w_free, w_byp;

    assign w_in_px     = {r_in, g_in, b_in};
    assign w_eff_w     = (width > MAX_W_V) ? MAX_W_V : width;
    assign w_row_start = (r_wr_col == '0);
    assign w_row_w     = w_row_start ? w_eff_w : r_bank_w[r_wr_bank];

    // Output stage loads whenever it is empty or being emptied this cycle.
    assign w_out_load = r_s1_valid && (!r_out_valid || out_ready);
    assign w_s1_free  = !r_s1_valid || w_out_load;
    assign w_free     = r_out_valid && out_ready && r_out_eol;

    // A draining bank whose eol pixel leaves this cycle may be refilled in the same cycle.
    assign w_wr_open = (r_st[r_wr_bank] == EMPTY) || (r_st[r_wr_bank] == FILLING) ||
                       (w_free && (r_out_bank == r_wr_bank));
    assign in_ready  = w_wr_open && (w_row_w != '0);
    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_last = (r_wr_col == w_row_w - ONE);

    // The last pixel of a row is the first to leave, so when the read side is idle
    // on this bank it goes straight into stage 1 instead of round-tripping the RAM.
    // This saves a cycle per row, which keeps both banks cycling without input stalls.
    assign w_byp = w_wr_fire && w_wr_last && (r_rd_bank == r_wr_bank) && !r_rd_busy && w_s1_free;

    assign w_rd_start = !r_rd_busy && (r_st[r_rd_bank] == FULL);
    assign w_rd_addr  = r_rd_busy ? r_rd_col : (r_bank_w[r_rd_bank] - ONE);
    assign w_rd_fire  = (w_rd_start || r_rd_busy) && w_s1_free;
    assign w_rd_last  = (w_rd_addr == '0);
    assign w_s1_px    = r_s1_byp ? r_byp_px : w_rdata[r_s1_bank];

    line_buffer_ram #(.DEPTH(MAX_WIDTH), .DATA_W(PIX_W), .ADDR_W(ADDR_W)) u_bank0 (
        .clk     (clk),
        .i_we    (w_wr_fire && (r_wr_bank == 1'b0)),
        .i_waddr (r_wr_col[ADDR_W-1:0]),
        .i_wdata (w_in_px),
        .i_re    (w_rd_fire && (r_rd_bank == 1'b0)),
        .i_raddr (w_rd_addr[ADDR_W-1:0]),
        .o_rdata (w_rdata[0])
    );

    line_buffer_ram #(.DEPTH(MAX_WIDTH), .DATA_W(PIX_W), .ADDR_W(ADDR_W)) u_bank1 (
        .clk     (clk),
        .i_we    (w_wr_fire && (r_wr_bank == 1'b1)),
        .i_waddr (r_wr_col[ADDR_W-1:0]),
        .i_wdata (w_in_px),
        .i_re    (w_rd_fire && (r_rd_bank == 1'b1)),
        .i_raddr (w_rd_addr[ADDR_W-1:0]),
        .o_rdata (w_rdata[1])
    );

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_st_nxt[b] = r_st[b];
            if (w_free && (r_out_bank == 1'(b))) begin
                w_st_nxt[b] = EMPTY;
            end
            if (w_rd_fire && w_rd_start && (r_rd_bank == 1'(b))) begin
                w_st_nxt[b] = DRAINING;
            end
            if (w_wr_fire && (r_wr_bank == 1'(b))) begin
                w_st_nxt[b] = !w_wr_last ? FILLING : (w_byp ? DRAINING : FULL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st[0] <= EMPTY;
            r_st[1] <= EMPTY;
        end else begin
            r_st[0] <= w_st_nxt[0];
            r_st[1] <= w_st_nxt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bank_w[0] <= '0;
            r_bank_w[1] <= '0;
            r_wr_bank   <= 1'b0;
            r_wr_col    <= '0;
            r_rd_bank   <= 1'b0;
            r_rd_busy   <= 1'b0;
            r_rd_col    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_byp    <= 1'b0;
            r_s1_eol    <= 1'b0;
            r_s1_bank   <= 1'b0;
            r_byp_px    <= '0;
            r_out_valid <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_bank  <= 1'b0;
            r_out_px    <= '0;
        end else begin
            if (w_wr_fire) begin
                if (w_row_start) begin
                    r_bank_w[r_wr_bank] <= w_eff_w;
                end
                if (w_wr_last) begin
                    r_wr_col  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_col <= r_wr_col + ONE;
                end
            end

            if (w_byp) begin
                r_s1_valid <= 1'b1;
                r_s1_byp   <= 1'b1;
                r_byp_px   <= w_in_px;
                r_s1_eol   <= (w_row_w == ONE);
                r_s1_bank  <= r_wr_bank;
                if (w_row_w == ONE) begin
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_busy <= 1'b1;
                    r_rd_col  <= w_row_w - TWO;
                end
            end else if (w_rd_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_byp   <= 1'b0;
                r_s1_eol   <= w_rd_last;
                r_s1_bank  <= r_rd_bank;
                if (w_rd_last) begin
                    r_rd_busy <= 1'b0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_busy <= 1'b1;
                    r_rd_col  <= w_rd_addr - ONE;
                end
            end else if (w_out_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_px    <= w_s1_px;
                r_out_eol   <= r_s1_eol;
                r_out_bank  <= r_s1_bank;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_eol   = r_out_eol;
    assign r_out     = r_out_px[3*CH_W-1:2*CH_W];
    assign g_out     = r_out_px[2*CH_W-1:CH_W];
    assign b_out     = r_out_px[CH_W-1:0];

endmodule

// File: tb/tb_flip_horizontal_stream.sv
// tb/tb_flip_horizontal_stream.sv - scoreboard bench for the horizontal flip stream
module tb_flip_horizontal_stream;
    import flip_pkg::*;

    typedef struct packed {
        pixel_t px;
        logic   eol;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] width;
    logic        in_valid, in_ready, out_valid, out_ready, out_eol;
    logic [7:0]  r_in, g_in, b_in, r_out, g_out, b_out;

    always #5 clk = ~clk;

    flip_horizontal_stream dut (
        .clk(clk), .rst_n(rst_n), .width(width),
        .in_valid(in_valid), .in_ready(in_ready),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .out_eol(out_eol)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [23:0] row_q[$];
    int          stall_cycles = 0;
    int          cyc = 0;
    bit          rand_mode = 0;
    logic        ready_val = 1'b1;
    bit          chk_cont = 0;
    bit          have_last = 0;
    int          last_cyc = 0;
    bit          prev_hold = 0;
    logic [23:0] prev_px;
    logic        prev_eol;
    exp_t        mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
            have_last = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_px", {r_out, g_out, b_out}, prev_px);
                check("hold_eol", out_eol, prev_eol);
            end
            if (!chk_cont) have_last = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", out_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_px", {r_out, g_out, b_out}, mon_e.px);
                    check("out_eol", out_eol, mon_e.eol);
                    if (chk_cont && have_last) check("out_gap", cyc - last_cyc, 1);
                    have_last = 1;
                    last_cyc  = cyc;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_px   = {r_out, g_out, b_out};
            prev_eol  = out_eol;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic send_px(input logic [23:0] px);
        int waits = 0;
        in_valid = 1'b1;
        {r_in, g_in, b_in} = px;
        @(negedge clk);
        while (!in_ready && waits < 500) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 500) check("in_ready_timeout", in_ready, 1'b1);
        stall_cycles += waits;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_row(input logic [12:0] w0, input logic [12:0] wmid);
        int n;
        n = (w0 > 13'd4096) ? 4096 : int'(w0);
        for (int i = 0; i < n; i++) begin
            if (i == 0) width = w0;
            send_px(row_q[i]);
            if (i == 0) width = wmid;
        end
        for (int i = n - 1; i >= 0; i--) sb.push_back({row_q[i], i == 0});
    endtask

    task automatic rand_row(input int n);
        row_q.delete();
        for (int i = 0; i < n; i++) row_q.push_back(24'($urandom));
    endtask

    task automatic wait_drain(input int limit);
        int t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("drain_left", sb.size(), 0);
        check("idle_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; width = 13'd4; in_valid = 1'b0;
        r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_eol", out_eol, 1'b0);
        check("rst_out_px", {r_out, g_out, b_out}, 24'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // width 4 directed row
        row_q = '{24'h010203, 24'h040506, 24'h070809, 24'h0a0b0c};
        send_row(13'd4, 13'd4);
        wait_drain(100);

        // width 1: three single-pixel rows, eol on each
        row_q = '{24'haa0000}; send_row(13'd1, 13'd1);
        row_q = '{24'h00bb00}; send_row(13'd1, 13'd1);
        row_q = '{24'h0000cc}; send_row(13'd1, 13'd1);
        wait_drain(100);

        // width 3: four rows back to back, continuous output, no input stall after row 1
        chk_cont = 1;
        rand_row(3); send_row(13'd3, 13'd3);
        stall_cycles = 0;
        for (int r = 0; r < 3; r++) begin
            rand_row(3);
            send_row(13'd3, 13'd3);
        end
        check("no_in_stall", stall_cycles, 0);
        wait_drain(100);
        chk_cont = 0;

        // width 4 with downstream stalled: both banks fill, then in_ready drops
        ready_val = 1'b0;
        rand_row(4); send_row(13'd4, 13'd4);
        rand_row(4); send_row(13'd4, 13'd4);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("both_full_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rand_mode = 1;
        for (int r = 0; r < 4; r++) begin
            rand_row(4);
            send_row(13'd4, 13'd4);
        end
        wait_drain(500);
        rand_mode = 0;
        ready_val = 1'b1;

        // reset with a buffered row and a partial row
        ready_val = 1'b0;
        rand_row(4); send_row(13'd4, 13'd4);
        send_px(24'h123456);
        send_px(24'h654321);
        check("pre_rst_out_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_val = 1'b1;
        row_q = '{24'h111111, 24'h222222};
        send_row(13'd2, 13'd2);
        wait_drain(100);

        // width changes: mid-row change ignored, between-row change honoured
        rand_row(4); send_row(13'd4, 13'd2);
        rand_row(2); send_row(13'd2, 13'd2);
        rand_row(4); send_row(13'd4, 13'd4);
        wait_drain(100);

        // width 0 at a row start accepts nothing
        width = 13'd0;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("w0_in_ready", in_ready, 1'b0);
        check("w0_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rand_row(2); send_row(13'd2, 13'd2);
        wait_drain(100);

        // width beyond the line buffer clamps to 4096
        rand_row(4096);
        send_row(13'd5000, 13'd5000);
        wait_drain(10000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
